// File: rtl/id_ex_pack_reg_if.sv
// ID/EX boundary bus: decode-side operands and controls in, packed bundle,
// valid flag and back-pressure out.
interface id_ex_pack_reg_if #(
  parameter int WIDTH = 166
);
  logic             id_valid;
  logic [31:0]      id_next_pc;
  logic [31:0]      id_op_a;
  logic [31:0]      id_op_b;
  logic [25:0]      id_offset26;
  logic [15:0]      id_offset16;
  logic [5:0]       id_opcode;
  logic [4:0]       id_dest_reg;
  logic [16:0]      id_ctrl;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             flush;
  logic             ex_stall;
  logic [0:WIDTH-1] out;
  logic             ex_valid;
  logic             id_stall;

  modport master (
    output id_valid, id_next_pc, id_op_a, id_op_b, id_offset26, id_offset16,
           id_opcode, id_dest_reg, id_ctrl, id_rs1, id_rs2, id_uses_rs1,
           id_uses_rs2, flush, ex_stall,
    input  out, ex_valid, id_stall
  );

  modport slave (
    input  id_valid, id_next_pc, id_op_a, id_op_b, id_offset26, id_offset16,
           id_opcode, id_dest_reg, id_ctrl, id_rs1, id_rs2, id_uses_rs1,
           id_uses_rs2, flush, ex_stall,
    output out, ex_valid, id_stall
  );
endinterface

// File: rtl/id_ex_pack_reg.sv
// ID/EX pipeline register: packs decode fields into the 166-bit bundle, inserts
// flush/load-use bubbles. Define ID_EX_MUL_STALL_EN to enable multi-cycle mul hold.
module id_ex_pack_reg #(
  parameter int WIDTH      = 166,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  id_ex_pack_reg_if.slave io
);
  // Bundle bit positions (bit 0 is the MSB of nextPC).
  localparam int B_DEST     = 144;
  localparam int B_REGWRITE = 155;
  localparam int B_MEMTOREG = 156;
  localparam int CTRL_MUL   = 6;   // mul flag inside id_ctrl[16:0]

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("MUL_CYCLES out of range 1..15");
  end

  logic [0:WIDTH-1] out_q, out_d, pack_w;
  logic             vld_q, vld_d;
  logic [4:0]       ex_dest;
  logic             rs1_hit, rs2_hit;
  logic             lu;
  logic             mul_busy;

  assign pack_w = {io.id_next_pc, io.id_op_a, io.id_op_b, io.id_offset26,
                   io.id_offset16, io.id_opcode, io.id_dest_reg, io.id_ctrl};

  assign ex_dest = out_q[B_DEST +: 5];
  assign rs1_hit = io.id_uses_rs1 && (io.id_rs1 == ex_dest);
  assign rs2_hit = io.id_uses_rs2 && (io.id_rs2 == ex_dest);
  assign lu      = vld_q && out_q[B_MEMTOREG] && out_q[B_REGWRITE] &&
                   (ex_dest != 5'd0) && (rs1_hit || rs2_hit) && io.id_valid;

`ifdef ID_EX_MUL_STALL_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [3:0] cnt_q, cnt_d;

  assign mul_busy = (cnt_q != 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (io.flush)
      cnt_d = 4'd0;
    else if (io.ex_stall)
      cnt_d = cnt_q;
    else if (mul_busy)
      cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    else if (lu)
      cnt_d = 4'd0;
    else if (io.id_valid && io.id_ctrl[CTRL_MUL])
      cnt_d = MUL_LOAD;
    else
      cnt_d = 4'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign mul_busy = 1'b0;
`endif

  // flush > ex_stall > mul hold > load-use bubble > normal load
  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (io.flush) begin
      out_d = '0;
      vld_d = 1'b0;
    end else if (io.ex_stall || mul_busy) begin
      out_d = out_q;
      vld_d = vld_q;
    end else if (lu) begin
      out_d = '0;
      vld_d = 1'b0;
    end else begin
      out_d = pack_w;
      vld_d = io.id_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign io.out      = out_q;
  assign io.ex_valid = vld_q;
  // Input ex_stall may be high during reset; keep ID free-running until release.
  assign io.id_stall = !reset && (io.ex_stall || lu || mul_busy);
endmodule

// File: tb/tb_id_ex_pack_reg.sv
// Randomized + directed bench for id_ex_pack_reg against a bit-level
// behavioural model of the ID/EX bundle.
module tb_id_ex_pack_reg;
  localparam int MUL_CYCLES = 4;
`ifdef ID_EX_MUL_STALL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif
  // control-field index k (0 = PCtoReg) lives at id_ctrl[16-k] and bundle bit 149+k
  localparam int K_REGWRITE = 6;
  localparam int K_MEMTOREG = 7;
  localparam int K_MUL      = 10;

  logic clock, reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  id_ex_pack_reg_if bus ();

  id_ex_pack_reg #(.WIDTH(166), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [165:0] act,
                       input logic [165:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [0:165] m_out;
  logic         m_vld;
  int           m_hold;

  function automatic logic [0:165] pack_model();
    logic [0:165] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i]       = bus.id_next_pc[31-i];
    for (int i = 0; i < 32; i++) b[32+i]    = bus.id_op_a[31-i];
    for (int i = 0; i < 32; i++) b[64+i]    = bus.id_op_b[31-i];
    for (int i = 0; i < 26; i++) b[96+i]    = bus.id_offset26[25-i];
    for (int i = 0; i < 16; i++) b[122+i]   = bus.id_offset16[15-i];
    for (int i = 0; i < 6;  i++) b[138+i]   = bus.id_opcode[5-i];
    for (int i = 0; i < 5;  i++) b[144+i]   = bus.id_dest_reg[4-i];
    for (int i = 0; i < 17; i++) b[149+i]   = bus.id_ctrl[16-i];
    return b;
  endfunction

  function automatic bit m_lu();
    logic [4:0] d;
    for (int i = 0; i < 5; i++) d[4-i] = m_out[144+i];
    return m_vld && m_out[149+K_MEMTOREG] && m_out[149+K_REGWRITE] && d != 0 &&
           bus.id_valid &&
           ((bus.id_uses_rs1 && bus.id_rs1 == d) || (bus.id_uses_rs2 && bus.id_rs2 == d));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_out = '0; m_vld = 1'b0; m_hold = 0;
    end else begin
      bit lu_now;
      lu_now = m_lu();
      if (bus.flush) begin
        m_out = '0; m_vld = 1'b0; m_hold = 0;
      end else if (bus.ex_stall) begin
        m_hold = m_hold;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end else if (lu_now) begin
        m_out = '0; m_vld = 1'b0;
      end else begin
        m_out = pack_model();
        m_vld = bus.id_valid;
        if (MULEN && bus.id_valid && bus.id_ctrl[16-K_MUL]) m_hold = MUL_CYCLES - 1;
      end
    end
  end

  // compare process: every cycle out of reset
  always @(negedge clock) begin
    if (!reset) begin
      check("ex_valid", 166'(bus.ex_valid), 166'(m_vld));
      check("id_stall", 166'(bus.id_stall),
            166'(bus.ex_stall || m_lu() || (m_hold > 0)));
      if (m_vld) check("out", bus.out, m_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_next_pc = 0; bus.id_op_a = 0; bus.id_op_b = 0;
    bus.id_offset26 = 0; bus.id_offset16 = 0; bus.id_opcode = 0;
    bus.id_dest_reg = 0; bus.id_ctrl = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.flush = 0; bus.ex_stall = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] dest,
                       input bit regw, input bit memtoreg, input bit mul);
    idle();
    bus.id_valid = 1; bus.id_next_pc = pc; bus.id_dest_reg = dest;
    bus.id_ctrl[16-K_REGWRITE] = regw;
    bus.id_ctrl[16-K_MEMTOREG] = memtoreg;
    bus.id_ctrl[16-K_MUL]      = mul;
  endtask

  task automatic mul_run(input bit with_stall, output int load_edge);
    int edges;
    instr(32'h200, 5'd7, 1, 0, 1);
    tick();
    edges = 1;
    instr(32'h300, 5'd8, 1, 0, 0);
    while (bus.out[0:31] != 32'h300 && edges < 20) begin
      if (with_stall) bus.ex_stall = (edges == 2 || edges == 3);
      tick();
      edges++;
    end
    bus.ex_stall = 0;
    load_edge = edges;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int le;
    int stalls;
    idle();
    reset = 1;
    repeat (3) @(posedge clock);
    #2 reset = 0;
    check("reset_out", bus.out, 166'd0);
    check("reset_vld", 166'(bus.ex_valid), 166'd0);

    // reset mid-operation
    instr(32'h104, 5'd3, 1, 0, 0);
    tick();
    check("pc_104", 166'(bus.out[0:31]), 166'(32'h104));
    check("regwrite_155", 166'(bus.out[155]), 166'd1);
    bus.ex_stall = 1;
    #1 reset = 1;
    #1;
    check("rst_async_out", bus.out, 166'd0);
    check("rst_async_vld", 166'(bus.ex_valid), 166'd0);
    check("rst_async_stall", 166'(bus.id_stall), 166'd0);
    bus.ex_stall = 0;
    #1 reset = 0;
    idle();
    tick();

    // load-use: lw r5 then add r?,r5
    instr(32'h600, 5'd5, 1, 1, 0);
    tick();
    instr(32'h604, 5'd6, 1, 0, 0);
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1;
    #1 check("lu_stall", 166'(bus.id_stall), 166'd1);
    tick();
    check("lu_bubble_vld", 166'(bus.ex_valid), 166'd0);
    check("lu_bubble_out", bus.out, 166'd0);
    #1 check("lu_stall_clear", 166'(bus.id_stall), 166'd0);
    tick();
    check("lu_add_vld", 166'(bus.ex_valid), 166'd1);
    check("lu_add_pc", 166'(bus.out[0:31]), 166'(32'h604));
    // same with dest = r0
    instr(32'h608, 5'd0, 1, 1, 0);
    tick();
    instr(32'h60C, 5'd6, 1, 0, 0);
    bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1;
    #1 check("lu_r0_nostall", 166'(bus.id_stall), 166'd0);
    tick();
    check("lu_r0_pc", 166'(bus.out[0:31]), 166'(32'h60C));

    // mul hold
    stalls = 0;
    instr(32'h200, 5'd7, 1, 0, 1);
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      #1 if (bus.id_stall) stalls++;
      tick();
    end
    check("mul_stall_cycles", 166'(stalls), 166'(MULEN ? MUL_CYCLES - 1 : 0));
    mul_run(0, le);
    check("mul_load_edge", 166'(le), 166'(MULEN ? MUL_CYCLES + 1 : 2));
    mul_run(1, le);
    check("mul_stall_load_edge", 166'(le), 166'(MULEN ? MUL_CYCLES + 3 : 2));

    // flush with ex_stall
    instr(32'h400, 5'd9, 1, 0, 0);
    tick();
    bus.flush = 1; bus.ex_stall = 1;
    #1 check("flush_stall_idstall", 166'(bus.id_stall), 166'd1);
    tick();
    check("flush_stall_vld", 166'(bus.ex_valid), 166'd0);
    check("flush_stall_out", bus.out, 166'd0);
    bus.flush = 0; bus.ex_stall = 0;
    #1 check("flush_stall_release", 166'(bus.id_stall), 166'd0);

    // flush during mul hold
    instr(32'h220, 5'd7, 1, 0, 1);
    tick();
    idle();
    tick();
    bus.flush = 1;
    tick();
    check("flush_mul_vld", 166'(bus.ex_valid), 166'd0);
    check("flush_mul_out", bus.out, 166'd0);
    instr(32'h500, 5'd2, 1, 0, 0);
    #1 check("flush_mul_cnt_clear", 166'(bus.id_stall), 166'd0);
    tick();
    check("flush_mul_next", 166'(bus.out[0:31]), 166'(32'h500));

    // field placement
    instr(32'h12345678, 5'b10110, 0, 0, 0);
    bus.id_op_a = 32'hDEADBEEF; bus.id_op_b = 32'h0BADF00D;
    bus.id_offset26 = 26'h2ABCDEF; bus.id_offset16 = 16'h8001;
    bus.id_opcode = 6'b100101;
    bus.id_ctrl = 17'b1_0_1_0_0_1_0_0_0_1_0_10_1010;
    tick();
    check("fld_pc_msb", 166'(bus.out[0]), 166'd0);
    check("fld_opa", 166'(bus.out[32:63]), 166'(32'hDEADBEEF));
    check("fld_opb", 166'(bus.out[64:95]), 166'(32'h0BADF00D));
    check("fld_off26", 166'(bus.out[96:121]), 166'(26'h2ABCDEF));
    check("fld_off16", 166'(bus.out[122:137]), 166'(16'h8001));
    check("fld_off16_bit122", 166'(bus.out[122]), 166'd1);
    check("fld_opcode", 166'(bus.out[138:143]), 166'(6'b100101));
    check("fld_dest", 166'(bus.out[144:148]), 166'(5'b10110));
    check("fld_pctoreg", 166'(bus.out[149]), 166'd1);
    check("fld_aluctrl", 166'(bus.out[162:165]), 166'(4'b1010));
    check("fld_dsize", 166'(bus.out[160:161]), 166'(2'b10));

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_next_pc  = $urandom;
      bus.id_op_a     = $urandom;
      bus.id_op_b     = $urandom;
      bus.id_offset26 = 26'($urandom);
      bus.id_offset16 = 16'($urandom);
      bus.id_opcode   = 6'($urandom);
      bus.id_dest_reg = 5'($urandom_range(0, 3));
      bus.id_ctrl     = 17'($urandom);
      bus.id_ctrl[16-K_MUL] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.id_ctrl[16-K_MEMTOREG] = 1;
        bus.id_ctrl[16-K_REGWRITE] = 1;
      end
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = $urandom_range(0, 1);
      bus.id_uses_rs2 = $urandom_range(0, 1);
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.ex_stall    = ($urandom_range(0, 6) == 0);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_pack_reg.md
# id_ex_pack_reg

Write side of the ID/EX pipeline boundary. Packs the decode stage's operands, offsets and control bits into the 166-bit ID/EX bundle and holds them in a clocked register. Inserts bubbles for flush and load-use hazards, and optionally holds multiply instructions in EX for several cycles. Produces the stall back to ID and the valid flag that travels with the bundle into EX.

## Interface
- `WIDTH`, 166, bundle width; fixed.
- `MUL_CYCLES`, 4, EX occupancy of a `mul` instruction in cycles; legal range 1..15.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID presents a real instruction
- `id_next_pc`  in  32  goes to bundle bits [0:31]
- `id_op_a`  in  32  goes to bundle bits [32:63]
- `id_op_b`  in  32  goes to bundle bits [64:95]
- `id_offset26`  in  26  goes to bundle bits [96:121]
- `id_offset16`  in  16  goes to bundle bits [122:137]
- `id_opcode`  in  6  goes to bundle bits [138:143]
- `id_dest_reg`  in  5  goes to bundle bits [144:148]
- `id_ctrl`  in  17  goes to bundle bits [149:165]; order is PCtoReg, RegToPC, jump, branch, branchZero, RType, RegWrite, MemToReg, MemWrite, loadSign, mul, DSize[0:1], ALUCtrl[0:3]
- `id_rs1`, `id_rs2`  in  5 each  source register numbers
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  source is actually read
- `flush`  in  1  squash the instruction entering EX (taken branch/jump)
- `ex_stall`  in  1  downstream cannot accept; hold the register
- `out`  out  166  registered bundle, bit 0 = MSB of nextPC
- `ex_valid`  out  1  `out` holds a real instruction
- `id_stall`  out  1  ID must hold its instruction this cycle

## Operation
- Bubble means `out`=0 and `ex_valid`=0. A bubble has RegWrite=0 and MemWrite=0.
- Load-use hazard (`lu`), combinational:
  - Conditions: `ex_valid`, `out`[156] (MemToReg), `out`[155] (RegWrite), and `out`[144:148] ≠ 0.
  - Plus at least one match: (`id_uses_rs1` and `id_rs1` = dest) or (`id_uses_rs2` and `id_rs2` = dest).
  - Plus `id_valid`.
- `mul_busy` = hold counter ≠ 0.
- `id_stall` = `ex_stall` | `lu` | `mul_busy`. Combinational, and never asserted during reset.
- Next-state priority, evaluated on each rising edge:
  1. `flush`: load a bubble and clear the counter.
  2. `ex_stall`: hold `out`, `ex_valid` and the counter unchanged.
  3. `mul_busy`: hold `out`/`ex_valid` and decrement the counter.
  4. `lu`: load a bubble.
  5. Otherwise: load the packed inputs, with `ex_valid` = `id_valid`. If `id_valid` and `id_ctrl` mul bit are set, the counter is loaded with `MUL_CYCLES`-1.
- With `id_valid`=0 in case 5, the data fields are still loaded as packed and `ex_valid`=0. EX ignores them; the bench checks only `ex_valid`.
- Counter: 4 bits, saturating decrement at 0, never wraps.

## Timing
- Reset (asynchronous, immediate): `out`=0, `ex_valid`=0, counter=0, `id_stall`=0. Effective mid-mul and mid-stall; no residual hold after release.
- Latency: inputs appear on `out` 1 cycle after the edge that samples them.
- Load-use: exactly one bubble. The dependent instruction loads on the following edge because the bubble clears `lu`.
- A mul occupies EX for `MUL_CYCLES` edges (absent `ex_stall`). `id_stall` is high for `MUL_CYCLES`-1 cycles starting the cycle after the mul loads.
- `ex_stall` during a mul hold freezes the counter, which extends the hold.
- `flush` together with `ex_stall`: flush wins and a bubble is loaded.
- `flush` together with `lu` or `mul_busy`: flush wins and the counter is cleared.
- `MUL_CYCLES`=1: no hold, and `mul_busy` is never set.

## Configuration
- `ID_EX_MUL_STALL_EN` defined: the multi-cycle multiply hold works as described above.
- `ID_EX_MUL_STALL_EN` undefined:
  - Counter logic is removed and `mul_busy` is constant 0.
  - A mul occupies EX for one cycle like any other instruction.
  - `MUL_CYCLES` is ignored.

## Test plan
- Reset pulse mid-operation (after loading nextPC=0x00000104, ctrl RegWrite=1) -> `out`=0, `ex_valid`=0 and `id_stall`=0 immediately, before the next edge.
- Load `lw r5` (MemToReg=1, RegWrite=1, dest=5), then `add` with `id_rs1`=5 and `id_uses_rs1`=1 -> `id_stall`=1 for one cycle, one bubble, then the add appears with `ex_valid`=1. Repeat with dest=0 -> no stall.
- Valid mul with `MUL_CYCLES`=4, macro defined -> `out` constant for 4 edges, `id_stall`=1 for 3 cycles, next instruction loads on edge 5. With the macro undefined -> next instruction loads on edge 2.
- Mul hold with `ex_stall`=1 for 2 cycles in the middle -> total EX occupancy 6 edges.
- `flush` asserted together with `ex_stall`, and again during a mul hold -> bubble loaded, counter 0, `id_stall` equal to `ex_stall` only.
- Random field values (e.g. opA=0xDEADBEEF, offset16=0x8001, ALUCtrl=0b1010) -> every bit lands at its stated bundle position, checked against an unpacking model.
